// File: rtl/hyperbus_pkg.sv
// Shared types for the HyperBus transmit path.
// Phase encoding, CA beat layout and write word bundle.
package hyperbus_pkg;

  localparam int CaWidth = 48;
  localparam int CaBeats = 3;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    DATA,
    DONE
  } tx_state_e;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
  } hyperbus_tx_word_t;

  // Byte pair for a CA beat, most significant pair first.
  function automatic logic [15:0] ca_pair(
    input logic [CaWidth-1:0] ca,
    input logic [1:0]         beat
  );
    logic [15:0] pair;
    unique case (beat)
      2'd0:    pair = ca[47:32];
      2'd1:    pair = ca[31:16];
      default: pair = ca[15:0];
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/hyperbus_tx_sequencer.sv
// HyperBus transmit sequencer: CA, write latency, then data burst.
// Emits registered DDR byte pairs for the PHY output converters.
module hyperbus_tx_sequencer
  import hyperbus_pkg::*;
#(
  parameter  int MaxLatency = 16,
  parameter  int BurstWidth = 16,
  localparam int LatWidth   = $clog2(MaxLatency + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  trans_valid_i,
  output logic                  trans_ready_o,
  input  logic [CaWidth-1:0]    trans_ca_i,
  input  logic [BurstWidth-1:0] trans_burst_i,
  input  logic [LatWidth-1:0]   latency_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic [15:0]           tx_data_i,
  input  logic [1:0]            tx_strb_i,
  output logic [7:0]            dq_d0_o,
  output logic [7:0]            dq_d1_o,
  output logic                  rwds_d0_o,
  output logic                  rwds_d1_o,
  output logic                  dq_oe_o,
  output logic                  rwds_oe_o,
  output logic                  clk_en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [LatWidth-1:0] LatMax =
    LatWidth'(MaxLatency);
  localparam logic [1:0] LastBeat = 2'(CaBeats - 1);

  tx_state_e state_q, state_d;

  logic [CaWidth-1:0]    ca_q, ca_d;
  logic                  write_q, write_d;
  logic [LatWidth-1:0]   cnt_q, cnt_d;
  logic [LatWidth-1:0]   lat_sat;
  logic [BurstWidth-1:0] words_q, words_d;
  logic [1:0]            beat_q, beat_d;

  logic [7:0] d0_q, d0_d;
  logic [7:0] d1_q, d1_d;
  logic       r0_q, r0_d;
  logic       r1_q, r1_d;
  logic       dq_oe_q, dq_oe_d;
  logic       rwds_oe_q, rwds_oe_d;
  logic       clk_en_q, clk_en_d;
  logic       done_q, done_d;

  hyperbus_tx_word_t word;
  logic              accept;
  logic              fire;

  assign word          = '{data: tx_data_i, strb: tx_strb_i};
  assign trans_ready_o = rst_ni && (state_q == IDLE);
  assign tx_ready_o    = (state_q == DATA)
                      && (words_q != '0);
  assign accept        = trans_valid_i && trans_ready_o;
  assign fire          = tx_valid_i && tx_ready_o;
  assign lat_sat       = (latency_i > LatMax) ? LatMax
                                              : latency_i;

  // State names the phase whose pair is loaded for the next cycle.
  always_comb begin
    state_d   = state_q;
    ca_d      = ca_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    beat_d    = beat_q;
    d0_d      = '0;
    d1_d      = '0;
    r0_d      = 1'b0;
    r1_d      = 1'b0;
    dq_oe_d   = 1'b0;
    rwds_oe_d = 1'b0;
    clk_en_d  = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ca_d         = trans_ca_i;
          write_d      = ~trans_ca_i[47];
          cnt_d        = lat_sat;
          words_d      = trans_burst_i;
          beat_d       = 2'd1;
          {d0_d, d1_d} = ca_pair(trans_ca_i, 2'd0);
          dq_oe_d      = 1'b1;
          clk_en_d     = 1'b1;
          state_d      = CA;
        end
      end
      CA: begin
        {d0_d, d1_d} = ca_pair(ca_q, beat_q);
        dq_oe_d      = 1'b1;
        clk_en_d     = 1'b1;
        beat_d       = beat_q + 2'd1;
        if (beat_q == LastBeat) begin
          beat_d = 2'd0;
          if (!write_q)
            state_d = DONE;
          else if (cnt_q != '0)
            state_d = LAT;
          else if (words_q != '0)
            state_d = DATA;
          else
            state_d = DONE;
        end
      end
      LAT: begin
        rwds_oe_d = 1'b1;
        clk_en_d  = 1'b1;
        cnt_d     = cnt_q - LatWidth'(1);
        if (cnt_q <= LatWidth'(1))
          state_d = (words_q != '0) ? DATA : DONE;
      end
      DATA: begin
        if (fire) begin
          {d0_d, d1_d} = word.data;
          r0_d         = ~word.strb[1];
          r1_d         = ~word.strb[0];
          dq_oe_d      = 1'b1;
          rwds_oe_d    = 1'b1;
          clk_en_d     = 1'b1;
          words_d      = words_q - BurstWidth'(1);
          if (words_q == BurstWidth'(1))
            state_d = DONE;
        end else begin
          // Underrun: stall the bus clock, keep the last pair.
          d0_d      = d0_q;
          d1_d      = d1_q;
          r0_d      = r0_q;
          r1_d      = r1_q;
          dq_oe_d   = dq_oe_q;
          rwds_oe_d = rwds_oe_q;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ca_q      <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      words_q   <= '0;
      beat_q    <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      r0_q      <= 1'b0;
      r1_q      <= 1'b0;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
      clk_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ca_q      <= ca_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
      beat_q    <= beat_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      dq_oe_q   <= dq_oe_d;
      rwds_oe_q <= rwds_oe_d;
      clk_en_q  <= clk_en_d;
      done_q    <= done_d;
    end
  end

  assign dq_d0_o   = d0_q;
  assign dq_d1_o   = d1_q;
  assign rwds_d0_o = r0_q;
  assign rwds_d1_o = r1_q;
  assign dq_oe_o   = dq_oe_q;
  assign rwds_oe_o = rwds_oe_q;
  assign clk_en_o  = clk_en_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: doc/hyperbus_tx_sequencer.md
Name: hyperbus_tx_sequencer

Overview:
- Upstream feeder of the PHY's single-to-double-data-rate output converters.
- Sequences one HyperBus transaction: a 48-bit command-address (CA) phase, a write-latency phase, then a burst of 16-bit write words.
- Emits per-cycle byte pairs: d0 is driven on the clock-high half, d1 on the clock-low half.
- The parent instantiates one DDR converter per DQ bit and one for RWDS, and gates the bus clock with clk_en_o.

Parameters:
- MaxLatency, 16: upper bound for latency_i; sets the latency counter width to $clog2(MaxLatency+1).
- BurstWidth, 16: width of trans_burst_i and of the word counter.

Ports:
- clk_i  in  1  PHY clock.
- rst_ni  in  1  Reset, synchronous, active-low.
- trans_valid_i  in  1  Transaction request.
- trans_ready_o  out  1  Request accepted when high together with trans_valid_i.
- trans_ca_i  in  48  Command-address word; bit 47 = R/W#.
- trans_burst_i  in  BurstWidth  Number of 16-bit write words.
- latency_i  in  $clog2(MaxLatency+1)  Write-latency clock cycles.
- tx_valid_i  in  1  Write word valid.
- tx_ready_o  out  1  Write word consumed.
- tx_data_i  in  16  Write word; [15:8] is the first byte.
- tx_strb_i  in  2  Byte enables; [1] pairs with [15:8].
- dq_d0_o  out  8  DQ byte for the high half.
- dq_d1_o  out  8  DQ byte for the low half.
- rwds_d0_o  out  1  RWDS for the high half.
- rwds_d1_o  out  1  RWDS for the low half.
- dq_oe_o  out  1  DQ output enable.
- rwds_oe_o  out  1  RWDS output enable.
- clk_en_o  out  1  Bus clock enable.
- busy_o  out  1  Transaction in progress.
- done_o  out  1  One-cycle completion pulse.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is synchronous, active-low.
- Reset values:
  - state = IDLE; all registered outputs 0.
  - trans_ready_o = 0 while rst_ni is low; otherwise trans_ready_o = (state == IDLE).
- Output timing: all d0/d1/oe/clk_en outputs are registered. Accept in cycle t gives the first CA pair on the outputs in t+1.
- Transaction capture: on accept, latch CA, burst, latency and write = ~trans_ca_i[47].
- FSM states: IDLE, CA, LAT, DATA, DONE.
- IDLE: outputs idle (oe=0, clk_en=0, d=0). Accept -> CA.
- CA (exactly 3 cycles, counter 0..2):
  - Pairs driven: {[47:40],[39:32]}, then {[31:24],[23:16]}, then {[15:8],[7:0]}.
  - dq_oe=1, rwds_oe=0, clk_en=1.
  - After the third pair: read -> DONE (the RX side owns the read latency and data); write -> LAT.
  - Write with latency_i = 0 skips LAT: burst 0 -> DONE, otherwise -> DATA.
- LAT (write only):
  - Counts exactly latency_i cycles.
  - dq_oe=0, rwds_oe=1, rwds_d0/d1=0, clk_en=1.
  - Exit -> DATA if burst != 0, else -> DONE.
- DATA:
  - tx_ready_o = 1 only in DATA and only while words remain; it is combinational from state and counter.
  - On a tx handshake:
    - dq_d0 = data[15:8], dq_d1 = data[7:0].
    - rwds_d0 = ~strb[1], rwds_d1 = ~strb[0] (RWDS high masks the byte).
    - dq_oe = rwds_oe = clk_en = 1.
    - Decrement the word counter.
  - tx_valid_i low (underrun): clk_en=0 on the next cycle; d outputs and oe hold their previous values; no count change. The bus clock stalls and no masked dummy word is ever emitted.
  - Last word consumed -> DONE.
- DONE (one cycle):
  - done_o=1.
  - oe=0, clk_en=0, d=0.
  - -> IDLE.
- Status and ordering:
  - busy_o = (state != IDLE).
  - Back-to-back transactions see at least one IDLE cycle between DONE and the next CA.
- Inputs only sampled at accept: trans_* inputs outside the accept cycle are ignored. latency_i > MaxLatency is saturated to MaxLatency.
- Reset mid-operation: on the next edge, return to IDLE with all outputs 0. The partial burst is dropped; no done_o pulse.

Decomposition:
- hyperbus_pkg:
  - tx_state_e enum (IDLE, CA, LAT, DATA, DONE).
  - CaWidth = 48 and CaBeats = 3.
  - hyperbus_tx_word_t struct {data[15:0], strb[1:0]}.
- No sub-module: counters and FSM stay in one file. The parent instantiates 8 DQ DDR converters plus 1 RWDS converter.

Test Plan:
- Write, CA=48'h0012_3456_789A, latency=3, burst=2, words 16'hA1B2/strb 2'b11 and 16'hC3D4/strb 2'b01, tx_valid always high -> expected outputs:
  - CA pairs (00,12), (34,56), (78,9A).
  - 3 LAT cycles with rwds_oe=1, dq_oe=0.
  - (A1,B2) with rwds 00, then (C3,D4) with rwds 10.
  - done_o in cycle t+9.
- Read, CA=48'h8000_0000_0010 -> expected: 3 CA cycles, DONE, IDLE; tx_ready_o never asserted; rwds_oe never asserted.
- Write, burst=4, tx_valid_i low for 2 cycles after word 1 -> expected:
  - clk_en_o=0 for exactly 2 cycles; outputs hold word 1.
  - Words 2..4 follow in order; exactly 4 tx handshakes.
- Edge cases:
  - latency=0 with burst=1 -> the DATA pair immediately follows the third CA pair.
  - burst=0 write -> CA, LAT, DONE with zero tx handshakes.
- Reset asserted in the 2nd DATA cycle of burst=8 -> next cycle: all outputs 0, busy_o=0, no done_o; a fresh transaction then completes normally.
- trans_valid_i held high continuously, 3 transactions -> expected: each accept only in IDLE, one IDLE gap between transactions, 3 done_o pulses.
